// File: rtl/wb_regfile_stage_pkg.sv
// Shared core definitions: datapath widths and writeback result-select encodings.
package wb_regfile_stage_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    // Also decoded by the control unit when it generates ResultSrc.
    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } result_src_e;

endpackage

// File: rtl/wb_regfile_stage_regfile_2r1w.sv
// Integer register file: one write port, two combinational read ports,
// same-cycle write-through bypass, x0 hardwired to zero, async active-low clear.
module regfile_2r1w
    import wb_regfile_stage_pkg::*;
#(
    parameter int unsigned DATA_W = wb_regfile_stage_pkg::XLEN,
    parameter int unsigned NREGS  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [REG_ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [REG_ADDR_W-1:0] i_raddr1,
    input  logic [REG_ADDR_W-1:0] i_raddr2,
    output logic [DATA_W-1:0]     o_rdata1,
    output logic [DATA_W-1:0]     o_rdata2
);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic              w_wen;

    assign w_wen = i_we && (i_waddr != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wen) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // x0 check first so a write aimed at x0 can never leak through the bypass.
    always_comb begin
        o_rdata1 = r_regs[i_raddr1];
        if (i_raddr1 == '0) begin
            o_rdata1 = '0;
        end else if (i_we && (i_waddr == i_raddr1)) begin
            o_rdata1 = i_wdata;
        end
    end

    always_comb begin
        o_rdata2 = r_regs[i_raddr2];
        if (i_raddr2 == '0) begin
            o_rdata2 = '0;
        end else if (i_we && (i_waddr == i_raddr2)) begin
            o_rdata2 = i_wdata;
        end
    end

endmodule

// File: rtl/wb_regfile_stage.sv
// Writeback stage: result select, register-file commit, commit trace for the
// verification monitor and the retired-instruction counter.
module wb_regfile_stage
    import wb_regfile_stage_pkg::*;
#(
    parameter int unsigned XLEN  = wb_regfile_stage_pkg::XLEN,
    parameter int unsigned NREGS = 32,
    parameter int unsigned CNT_W = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  InstrValidW,
    input  logic                  RegWriteW,
    input  logic [1:0]            ResultSrcW,
    input  logic [XLEN-1:0]       ALUResultW,
    input  logic [XLEN-1:0]       ReadDataW,
    input  logic [XLEN-1:0]       PCPlus4W,
    input  logic [XLEN-1:0]       ImmExtW,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    output logic [XLEN-1:0]       RD1D,
    output logic [XLEN-1:0]       RD2D,
    output logic [XLEN-1:0]       ResultW,
    output logic                  CommitValid,
    output logic [REG_ADDR_W-1:0] CommitRd,
    output logic [XLEN-1:0]       CommitData,
    output logic [CNT_W-1:0]      InstRet
);

    logic                  r_commit_valid;
    logic [REG_ADDR_W-1:0] r_commit_rd;
    logic [XLEN-1:0]       r_commit_data;
    logic [CNT_W-1:0]      r_instret;
    logic [XLEN-1:0]       w_result;
    logic                  w_commit_wr;

    always_comb begin
        w_result = ALUResultW;
        case (result_src_e'(ResultSrcW))
            RES_ALU: w_result = ALUResultW;
            RES_MEM: w_result = ReadDataW;
            RES_PC4: w_result = PCPlus4W;
            RES_IMM: w_result = ImmExtW;
            default: w_result = ALUResultW;
        endcase
    end

    assign ResultW     = w_result;
    assign w_commit_wr = InstrValidW && RegWriteW && (RdW != '0);

    regfile_2r1w #(
        .DATA_W (XLEN),
        .NREGS  (NREGS)
    ) u_regfile (
        .i_clk    (clk),
        .i_rst_n  (reset),
        .i_we     (RegWriteW),
        .i_waddr  (RdW),
        .i_wdata  (w_result),
        .i_raddr1 (Rs1D),
        .i_raddr2 (Rs2D),
        .o_rdata1 (RD1D),
        .o_rdata2 (RD2D)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_commit_valid <= 1'b0;
            r_commit_rd    <= '0;
            r_commit_data  <= '0;
            r_instret      <= '0;
        end else begin
            r_commit_valid <= InstrValidW;
            r_commit_rd    <= w_commit_wr ? RdW : '0;
            r_commit_data  <= w_commit_wr ? w_result : '0;
            if (InstrValidW) begin
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

    assign CommitValid = r_commit_valid;
    assign CommitRd    = r_commit_rd;
    assign CommitData  = r_commit_data;
    assign InstRet     = r_instret;

endmodule

// File: doc/wb_regfile_stage.md
Name: wb_regfile_stage

Overview:
- Consumer end of the MEM/WB pipeline register in the 5-stage RISC-V core.
- Selects the writeback result from the W-stage fields and commits it to the 32x32 integer register file.
- Serves the two decode-stage read ports with same-cycle write-through bypass.
- Keeps a 64-bit retired-instruction counter and a registered commit trace for the verification monitor.

Parameters:
- XLEN, 32, data width of registers and result
- NREGS, 32, number of architectural registers; x0 is hardwired to zero
- CNT_W, 64, width of the retired-instruction counter

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low; registers clear while reset=0
- InstrValidW  in  1  a real (non-bubble) instruction occupies W this cycle
- RegWriteW  in  1  write enable from MEM/WB
- ResultSrcW  in  2  result select: 00 ALUResultW, 01 ReadDataW, 10 PCPlus4W, 11 ImmExtW
- ALUResultW  in  XLEN  ALU result
- ReadDataW  in  XLEN  load data
- PCPlus4W  in  XLEN  link value for JAL/JALR
- ImmExtW  in  XLEN  extended immediate (LUI)
- RdW  in  5  destination register
- Rs1D  in  5  decode read address 1
- Rs2D  in  5  decode read address 2
- RD1D  out  XLEN  read data 1
- RD2D  out  XLEN  read data 2
- ResultW  out  XLEN  selected writeback value, combinational, also used by the forwarding mux
- CommitValid  out  1  registered: an instruction retired last cycle
- CommitRd  out  5  registered rd of the retired instruction; 0 if it did not write
- CommitData  out  XLEN  registered value written; 0 if no write
- InstRet  out  CNT_W  retired-instruction count

Behaviour:
- Reset (reset=0, asynchronous):
  - all 32 registers clear to 0.
  - CommitValid=0, CommitRd=0, CommitData=0, InstRet=0.
  - Assertion takes effect immediately, mid-cycle or mid-write; any in-flight write is lost.
  - Deassertion is sampled at the next clk edge.
- ResultW: pure 4:1 mux on ResultSrcW. All four codes are legal.
- Write rule: at posedge clk, regs[RdW] <= ResultW iff RegWriteW=1 and RdW!=0.
  - InstrValidW does not gate the write; upstream already clears RegWriteW on bubbles.
  - RdW=0: no state change; x0 always reads 0.
- Read ports:
  - RDnD = 0 if RsnD=0.
  - Otherwise RDnD = ResultW if RegWriteW=1 and RdW=RsnD (write-through bypass, same cycle).
  - Otherwise RDnD = regs[RsnD].
  - Fully combinational, zero latency.
  - Both ports may hit the same register and the bypass simultaneously.
- Commit trace, 1-cycle latency: at posedge, CommitValid <= InstrValidW.
  - If InstrValidW=1 and RegWriteW=1 and RdW!=0: CommitRd <= RdW, CommitData <= ResultW.
  - Otherwise CommitRd <= 0, CommitData <= 0.
- InstRet:
  - increments by 1 on each posedge with InstrValidW=1; holds otherwise.
  - Wraps modulo 2^CNT_W: all-ones -> 0 with no flag.
  - Stores and branches count (InstrValidW=1, RegWriteW=0).
- No stall input: the W stage never stalls. The pipeline register presents a bubble instead.
- No X propagation: unknown ResultSrcW is not permitted after reset. Assertion in bench only.

Decomposition:
- Shared core package holds:
  - ResultSrc encodings RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10, RES_IMM=2'b11, also used by the control decoder.
  - XLEN and REG_ADDR_W=5.
- Natural sub-module: regfile_2r1w, the 32-entry array with async-clear, one write port, two read ports and bypass.
- The top wb_regfile_stage holds the result mux, commit trace and InstRet counter.

Test Plan:
- Reset mid-write: write x5=0xDEADBEEF, then drop reset=0 between clock edges -> x5 reads 0 immediately; InstRet=0; CommitValid=0.
- Result mux: RdW=1..4 with ResultSrcW=00/01/10/11, ALU=0x11, Read=0x22, PC4=0x33, Imm=0x44000 -> x1=0x11, x2=0x22, x3=0x33, x4=0x44000; CommitData matches one cycle later.
- x0 protection: RegWriteW=1, RdW=0, ALUResult=0xFFFFFFFF -> RD1D with Rs1D=0 reads 0; CommitRd=0, CommitData=0, CommitValid=1.
- Bypass: x7 holds 0x10; same cycle RegWriteW=1, RdW=7, ResultW=0x99, Rs1D=Rs2D=7 -> RD1D=RD2D=0x99 combinationally; next cycle reads 0x99 without the write.
- Non-writing retire: InstrValidW=1, RegWriteW=0 for 3 cycles, then 2 bubbles -> InstRet=3; no register changes; CommitValid pattern 1,1,1,0,0.
- Counter wrap: force InstRet=64'hFFFF_FFFF_FFFF_FFFF, one valid instruction -> InstRet=0.
